// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory read-back UART transmitter:
// the FSM state encoding, the UART frame length and word/byte sizing.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_SEND,
    ST_NEXT,
    ST_FINISH
  } dump_state_t;

  localparam int UART_FRAME_BITS   = 10;
  localparam int DEFAULT_DATA_SIZE = 32;
  localparam int BYTES_PER_WORD    = DEFAULT_DATA_SIZE / 8;

  function automatic int bytes_per_word(input int data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. byte_ready is also high in the last stop-bit cycle
// so a waiting byte starts its start bit with no idle gap.
module uart_tx_byte
  import mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       sys_clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic              active;
  logic [3:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [8:0]        shift;
  logic              last_cycle;

  assign last_cycle = active && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_LAST);
  assign byte_ready = !active || last_cycle;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block behaves like real flops.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      active   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shift    <= 9'h1ff;
      tx       <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      // Stop bit rides in the top of the shift register behind the data.
      active   <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shift    <= {1'b1, byte_data};
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active  <= 1'b0;
          bit_cnt <= '0;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Walks an address range of a synchronous-read memory and sends each word
// off-chip as DATA_SIZE/8 UART bytes, most significant byte first.
module mem_dump_tx
  import mem_dump_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int ADRS_WIDTH   = 11,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADRS_WIDTH-1:0] base_adrs,
  input  logic [ADRS_WIDTH:0]   word_count,
  output logic [ADRS_WIDTH-1:0] rd_adrs,
  output logic                  rd_en,
  input  logic [DATA_SIZE-1:0]  rd_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int               BYTES    = bytes_per_word(DATA_SIZE);
  localparam int               IDX_W    = $clog2(BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES);

  dump_state_t           state;
  logic [ADRS_WIDTH-1:0] adrs_cnt;
  logic [ADRS_WIDTH:0]   remaining;
  logic [DATA_SIZE-1:0]  word;
  logic [IDX_W-1:0]      byte_idx;

  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       handshake;

  // Byte 0 is handed over straight from rd_data during CAPTURE, so the first
  // start bit follows CAPTURE with no extra idle cycle on the line.
  // NOTE: defaults come first so every path assigns and no latch is inferred.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = word[DATA_SIZE-1 -: 8];
    case (state)
      ST_CAPTURE: begin
        byte_valid = 1'b1;
        byte_data  = rd_data[DATA_SIZE-1 -: 8];
      end
      ST_SEND:  byte_valid = (byte_idx != IDX_LAST);
      default:  byte_valid = 1'b0;
    endcase
  end

  assign handshake = byte_valid && byte_ready;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      adrs_cnt  <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
      rd_adrs   <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            adrs_cnt  <= base_adrs;
            remaining <= word_count;
            busy      <= 1'b1;
            if (word_count == '0) begin
              state <= ST_FINISH;
            end else begin
              state   <= ST_ISSUE;
              rd_en   <= 1'b1;
              rd_adrs <= base_adrs;
            end
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          word     <= rd_data << 8;
          byte_idx <= IDX_W'(1);
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (handshake) begin
            word     <= word << 8;
            byte_idx <= byte_idx + IDX_W'(1);
          end else if ((byte_idx == IDX_LAST) && byte_ready) begin
            // Last byte is in its final stop-bit cycle.
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          adrs_cnt  <= adrs_cnt + ADRS_WIDTH'(1);
          remaining <= remaining - (ADRS_WIDTH + 1)'(1);
          if (remaining == (ADRS_WIDTH + 1)'(1)) begin
            state <= ST_FINISH;
          end else begin
            state   <= ST_ISSUE;
            rd_en   <= 1'b1;
            rd_adrs <= adrs_cnt + ADRS_WIDTH'(1);
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .sys_clk   (sys_clk),
    .resetn    (resetn),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (tx)
  );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: 1-cycle-latency RAM model, UART receive
// model with gap tracking, one task per scenario.
module tb_mem_dump_tx;

  localparam int DATA_SIZE   = 32;
  localparam int ADRS_WIDTH  = 11;
  localparam int CPB         = 4;
  localparam int PERIOD      = 10;
  localparam int WORD_CYCLES = 40 * CPB + 3;
  localparam int BUDGET      = 3000;

  logic                  sys_clk = 1'b0;
  logic                  resetn  = 1'b0;
  logic                  start   = 1'b0;
  logic [ADRS_WIDTH-1:0] base_adrs  = '0;
  logic [ADRS_WIDTH:0]   word_count = '0;
  logic [ADRS_WIDTH-1:0] rd_adrs;
  logic                  rd_en;
  logic [DATA_SIZE-1:0]  rd_data = '0;
  logic                  tx;
  logic                  busy;
  logic                  done;

  int total = 0;
  int bad   = 0;

  logic [DATA_SIZE-1:0]  mem [0:(1<<ADRS_WIDTH)-1];
  int                    rd_en_cnt;
  int                    done_cnt;
  bit                    tx_low_seen;
  logic [ADRS_WIDTH-1:0] adrs_log [$];
  logic [7:0]            rx_q [$];
  int                    gap_q [$];
  bit                    have_prev;
  longint                prev_end;
  int                    frame_err;

  always #(PERIOD/2) sys_clk = ~sys_clk;

  mem_dump_tx #(
    .DATA_SIZE   (DATA_SIZE),
    .ADRS_WIDTH  (ADRS_WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .sys_clk   (sys_clk),
    .resetn    (resetn),
    .start     (start),
    .base_adrs (base_adrs),
    .word_count(word_count),
    .rd_adrs   (rd_adrs),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge sys_clk) if (rd_en) rd_data <= mem[rd_adrs];

  always @(negedge sys_clk) begin
    if (rd_en) begin
      rd_en_cnt++;
      adrs_log.push_back(rd_adrs);
    end
    if (done) done_cnt++;
    if (tx === 1'b0) tx_low_seen = 1'b1;
  end

  // UART receiver: sampled on negedges, one sample per bit at a fixed phase.
  initial begin : uart_rx
    logic [7:0] byte_v;
    longint     s;
    forever begin
      @(negedge sys_clk);
      if (tx === 1'b0) begin
        s = longint'($time);
        if (have_prev) gap_q.push_back(int'((s - prev_end) / PERIOD));
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge sys_clk);
          byte_v[b] = tx;
        end
        repeat (CPB) @(negedge sys_clk);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(byte_v);
        prev_end  = s + longint'(10 * CPB * PERIOD);
        have_prev = 1'b1;
      end
    end
  end

  task automatic clear_obs();
    rx_q.delete();
    gap_q.delete();
    adrs_log.delete();
    have_prev   = 1'b0;
    rd_en_cnt   = 0;
    done_cnt    = 0;
    tx_low_seen = 1'b0;
    frame_err   = 0;
  endtask

  // lat counts posedges from the one that samples start up to the one after
  // which done is high: sample edge, FINISH edge, plus each word's period.
  task automatic run_xfer(input logic [ADRS_WIDTH-1:0] b, input logic [ADRS_WIDTH:0] n,
                          output int lat, output bit ok);
    @(negedge sys_clk);
    base_adrs  = b;
    word_count = n;
    start      = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    total++; if (tx !== 1'b1)      begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rd_en !== 1'b0)   begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    total++; if (rd_adrs !== '0)   begin bad++; $display("FAIL reset_rd_adrs: got %h want 000", rd_adrs); end
    @(negedge sys_clk);
    resetn = 1'b1;
    repeat (2) @(negedge sys_clk);
    clear_obs();
  endtask

  task automatic test_single();
    int lat; bit ok;
    logic [7:0] exp_b [$];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h84};
    clear_obs();
    run_xfer(11'h002, 12'd1, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no done want done"); end
    total++; if (lat !== 2 + WORD_CYCLES) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, 2 + WORD_CYCLES); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_at_done: got %b want 0", busy); end
    repeat (4) @(negedge sys_clk);
    total++; if (rx_q.size() !== exp_b.size()) begin bad++; $display("FAIL single_nbytes: got %0d want %0d", rx_q.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    total++; if (rd_en_cnt !== 1) begin bad++; $display("FAIL single_rd_en_cnt: got %0d want 1", rd_en_cnt); end
    total++; if (adrs_log.size() < 1 || adrs_log[0] !== 11'h002) begin bad++; $display("FAIL single_rd_adrs: got %0d entries want first 002", adrs_log.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    total++; if (frame_err !== 0) begin bad++; $display("FAIL single_framing: got %0d want 0", frame_err); end
  endtask

  task automatic test_multi();
    int lat; bit ok;
    logic [7:0] exp_b [$];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h0b, 8'h00, 8'h00, 8'h00, 8'h0c, 8'h00, 8'h00, 8'h00, 8'h84};
    clear_obs();
    run_xfer(11'h000, 12'd3, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL multi_timeout: got no done want done"); end
    total++; if (lat !== 2 + 3 * WORD_CYCLES) begin bad++; $display("FAIL multi_latency: got %0d want %0d", lat, 2 + 3 * WORD_CYCLES); end
    repeat (4) @(negedge sys_clk);
    total++; if (rx_q.size() !== exp_b.size()) begin bad++; $display("FAIL multi_nbytes: got %0d want %0d", rx_q.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL multi_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    // Bytes within a word are back-to-back; word boundaries leave 3 idle cycles.
    total++; if (gap_q.size() !== 11) begin bad++; $display("FAIL multi_ngaps: got %0d want 11", gap_q.size()); end
    else for (int g = 0; g < 11; g++) begin
      total++;
      if (gap_q[g] !== (((g + 1) % 4 == 0) ? 3 : 0)) begin
        bad++; $display("FAIL multi_gap%0d: got %0d want %0d", g, gap_q[g], ((g + 1) % 4 == 0) ? 3 : 0);
      end
    end
    total++; if (rd_en_cnt !== 3) begin bad++; $display("FAIL multi_rd_en_cnt: got %0d want 3", rd_en_cnt); end
  endtask

  task automatic test_wrap();
    int lat; bit ok;
    logic [7:0] exp_b [$];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0b};
    clear_obs();
    run_xfer(11'h7ff, 12'd2, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got no done want done"); end
    total++; if (lat !== 2 + 2 * WORD_CYCLES) begin bad++; $display("FAIL wrap_latency: got %0d want %0d", lat, 2 + 2 * WORD_CYCLES); end
    repeat (4) @(negedge sys_clk);
    total++; if (adrs_log.size() !== 2) begin bad++; $display("FAIL wrap_nreads: got %0d want 2", adrs_log.size()); end
    else begin
      total++; if (adrs_log[0] !== 11'h7ff) begin bad++; $display("FAIL wrap_adrs0: got %h want 7ff", adrs_log[0]); end
      total++; if (adrs_log[1] !== 11'h000) begin bad++; $display("FAIL wrap_adrs1: got %h want 000", adrs_log[1]); end
    end
    total++; if (rx_q.size() !== exp_b.size()) begin bad++; $display("FAIL wrap_nbytes: got %0d want %0d", rx_q.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero();
    int lat; bit ok;
    clear_obs();
    run_xfer(11'h005, 12'd0, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_timeout: got no done want done"); end
    total++; if (lat !== 2) begin bad++; $display("FAIL zero_latency: got %0d want 2", lat); end
    repeat (10) @(negedge sys_clk);
    total++; if (tx_low_seen !== 1'b0) begin bad++; $display("FAIL zero_tx_low: got %b want 0", tx_low_seen); end
    total++; if (rd_en_cnt !== 0) begin bad++; $display("FAIL zero_rd_en_cnt: got %0d want 0", rd_en_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_busy_ignore();
    int lat; bit ok;
    logic [7:0] exp_b [$];
    exp_b = '{8'hff, 8'hff, 8'hff, 8'hff};
    clear_obs();
    @(negedge sys_clk);
    base_adrs  = 11'h0ff;
    word_count = 12'd1;
    start      = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge sys_clk);
      #1;
      lat++;
      if (done) begin
        start = 1'b0;
        ok    = 1'b1;
        break;
      end
      @(negedge sys_clk);
      start      = busy;
      base_adrs  = 11'h000;
      word_count = 12'd3;
    end
    start = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got no done want done"); end
    total++; if (lat !== 2 + WORD_CYCLES) begin bad++; $display("FAIL busy_latency: got %0d want %0d", lat, 2 + WORD_CYCLES); end
    repeat (20) @(negedge sys_clk);
    total++; if (rd_en_cnt !== 1) begin bad++; $display("FAIL busy_rd_en_cnt: got %0d want 1", rd_en_cnt); end
    total++; if (adrs_log.size() < 1 || adrs_log[0] !== 11'h0ff) begin bad++; $display("FAIL busy_rd_adrs: got %0d entries want first 0ff", adrs_log.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after: got %b want 0", busy); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
    total++; if (rx_q.size() !== exp_b.size()) begin bad++; $display("FAIL busy_nbytes: got %0d want %0d", rx_q.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL busy_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; bit reached;
    logic [7:0] exp_b [$];
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h84};
    clear_obs();
    @(negedge sys_clk);
    base_adrs  = 11'h000;
    word_count = 12'd3;
    start      = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge sys_clk);
      if (rx_q.size() >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    total++; if (!reached) begin bad++; $display("FAIL rstmid_timeout: got %0d bytes want 2", rx_q.size()); end
    // Lands in data bit 1 of byte 2 (value 0x00), so the line is low here.
    repeat (3 * CPB) @(negedge sys_clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_pre_tx: got %b want 0", tx); end
    resetn = 1'b0;
    #1;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (2) @(negedge sys_clk);
    resetn = 1'b1;
    repeat (12 * CPB) @(negedge sys_clk);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstmid_done_cnt: got %0d want 0", done_cnt); end
    clear_obs();
    run_xfer(11'h002, 12'd1, lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_restart_timeout: got no done want done"); end
    total++; if (lat !== 2 + WORD_CYCLES) begin bad++; $display("FAIL rstmid_restart_latency: got %0d want %0d", lat, 2 + WORD_CYCLES); end
    repeat (4) @(negedge sys_clk);
    total++; if (rx_q.size() !== exp_b.size()) begin bad++; $display("FAIL rstmid_nbytes: got %0d want %0d", rx_q.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      total++; if (rx_q[i] !== exp_b[i]) begin bad++; $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADRS_WIDTH); i++) mem[i] = '0;
    mem[0]   = 32'h0000_000b;
    mem[1]   = 32'h0000_000c;
    mem[2]   = 32'h0000_0084;
    mem[255] = 32'hffff_ffff;
    clear_obs();

    test_reset();
    test_single();
    test_multi();
    test_wrap();
    test_zero();
    test_busy_ignore();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
